// File: rtl/fifo_pkg.sv
// Shared constants and state type for the delay-FIFO drain block.
// Defaults size the attached FIFO to 8 x 64-bit entries.
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_BITS  = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } drain_state_t;

endpackage

// File: rtl/fifo_drain.sv
// Drains DEPTH entries from an attached shift FIFO onto a valid/ready port.
// Optional FIFO_DRAIN_RESTORE_EN recirculates entries for a non-destructive read.
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int BITS  = FIFO_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] fifo_q,
  output logic            fifo_en,
  output logic [BITS-1:0] fifo_d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(DEPTH) + 1;

  drain_state_t  state;
  drain_state_t  state_n;
  logic [CW-1:0] cnt;

  // State register, entry counter and captured output data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        cnt <= '0;
      end else if (state == LOAD) begin
        cnt <= cnt + CW'(1);
      end
      if (state == LOAD) begin
        out_data <= fifo_q;
      end
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        state_n = SEND;
      end
      SEND: begin
        if (out_ready) begin
          state_n = (cnt == CW'(DEPTH)) ? DONE : LOAD;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    fifo_en   = (state == LOAD);
    out_valid = (state == SEND);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

`ifdef FIFO_DRAIN_RESTORE_EN
  assign fifo_d = fifo_q;
`else
  assign fifo_d = '0;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain with a behavioural 8-deep shift FIFO attached.
// Expected values are hand-derived constants.
module tb_fifo_drain;
  import fifo_pkg::*;

  localparam int D = FIFO_DEPTH;
  localparam int B = FIFO_BITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [B-1:0] fifo_q;
  logic         fifo_en;
  logic [B-1:0] fifo_d;
  logic         out_valid;
  logic         out_ready;
  logic [B-1:0] out_data;
  logic         busy;
  logic         done;

  logic [B-1:0] mem [D];
  logic [B-1:0] fill_val [D];
  logic         fill_req = 1'b0;

  logic [B-1:0] got [$];
  int           en_cnt = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;
  int           cyc = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_drain #(.DEPTH(D), .BITS(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .fifo_q    (fifo_q),
    .fifo_en   (fifo_en),
    .fifo_d    (fifo_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  assign fifo_q = mem[D-1];

  // Attached delay FIFO: mem[D-1] is the oldest entry.
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < D; i++) mem[i] <= fill_val[i];
    end else if (fifo_en) begin
      for (int i = D - 1; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= fifo_d;
    end
  end

  // Edge monitor: sees the values present just before each edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (fifo_en) en_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [B-1:0] obs,
                       input logic [B-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [B-1:0] base);
    for (int i = 0; i < D; i++) fill_val[D-1-i] = base + B'(i);
    @(negedge clk);
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  task automatic pulse_start(output int s_cyc);
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", B'(done_cnt != d0), B'(1));
  endtask

  task automatic check_entries(input string tag, input int base,
                               input logic [B-1:0] first);
    logic [B-1:0] v;
    check({tag, "_count"}, B'(got.size() - base), B'(D));
    for (int i = 0; i < D; i++) begin
      v = (base + i < got.size()) ? got[base+i] : 'x;
      check({tag, "_entry"}, v, first + B'(i));
    end
  endtask

  initial begin
    int s_cyc;
    int g0;
    int e0;
    int d0;
    int n;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < D; i++) fill_val[i] = '0;
    #1;
    check("rst_valid", B'(out_valid), B'(0));
    check("rst_busy", B'(busy), B'(0));
    check("rst_en", B'(fifo_en), B'(0));
    check("rst_done", B'(done), B'(0));
    check("rst_data", out_data, B'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full drain with out_ready held high.
    fill(B'(1));
    g0 = got.size(); e0 = en_cnt; d0 = done_cnt;
    pulse_start(s_cyc);
    wait_done(d0);
    check_entries("drain", g0, B'(1));
    check("drain_en_pulses", B'(en_cnt - e0), B'(D));
    check("drain_done_pulses", B'(done_cnt - d0), B'(1));
    check("drain_latency", B'(done_cyc - s_cyc), B'(17));
    @(negedge clk);
    check("drain_idle", B'(busy), B'(0));
    for (int i = 0; i < D; i++) begin
`ifdef FIFO_DRAIN_RESTORE_EN
      check("fifo_after", mem[D-1-i], B'(i + 1));
`else
      check("fifo_after", mem[D-1-i], B'(0));
`endif
    end

    // Consumer stalls for 5 cycles on entry 3.
    fill(B'(1));
    g0 = got.size(); d0 = done_cnt;
    pulse_start(s_cyc);
    n = 0;
    while (!(out_valid && out_data == B'(3)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_found", B'(out_valid && out_data == B'(3)), B'(1));
    out_ready = 1'b0;
    e0 = en_cnt;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", B'(out_valid), B'(1));
      check("stall_data", out_data, B'(3));
      check("stall_en", B'(fifo_en), B'(0));
    end
    check("stall_en_pulses", B'(en_cnt - e0), B'(0));
    out_ready = 1'b1;
    wait_done(d0);
    check_entries("stall", g0, B'(1));

    // Extra start pulses while busy, including during DONE.
    fill(B'(1));
    g0 = got.size(); e0 = en_cnt; d0 = done_cnt;
    pulse_start(s_cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_done_seen", B'(done), B'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_idle", B'(busy), B'(0));
    check_entries("busy", g0, B'(1));
    check("busy_en_pulses", B'(en_cnt - e0), B'(D));
    check("busy_done_pulses", B'(done_cnt - d0), B'(1));

    // Reset after 3 accepted entries, then a fresh drain.
    fill(B'(1));
    g0 = got.size();
    pulse_start(s_cyc);
    n = 0;
    while (got.size() - g0 < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_accepted", B'(got.size() - g0), B'(3));
    check("mid_en_before", B'(fifo_en), B'(1));
    rst_n = 1'b0;
    #1;
    check("mid_valid", B'(out_valid), B'(0));
    check("mid_busy", B'(busy), B'(0));
    check("mid_en", B'(fifo_en), B'(0));
    check("mid_data", out_data, B'(0));
    e0 = en_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_no_pulses", B'(en_cnt - e0), B'(0));
    check("mid_idle", B'(busy), B'(0));
    fill(B'('hA0));
    g0 = got.size(); e0 = en_cnt; d0 = done_cnt;
    pulse_start(s_cyc);
    wait_done(d0);
    check_entries("refill", g0, B'('hA0));
    check("refill_en_pulses", B'(en_cnt - e0), B'(D));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 Parameter DEPTH, default 8, number of entries in the attached delay FIFO to drain per transaction.
REQ-002 Parameter BITS, default 64, width of each FIFO entry.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a drain transaction.
REQ-006 fifo_q  input  BITS  oldest entry presented by the attached delay FIFO.
REQ-007 fifo_en  output  1  shift enable driven to the attached delay FIFO.
REQ-008 fifo_d  output  BITS  data shifted into the attached delay FIFO when fifo_en is high.
REQ-009 out_valid  output  1  out_data holds a drained entry.
REQ-010 out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.
REQ-011 out_data  output  BITS  drained entry, oldest first.
REQ-012 busy  output  1  a transaction is in progress (state not IDLE).
REQ-013 done  output  1  one-cycle pulse after the last entry is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, SEND and DONE, plus an entry counter of width $clog2(DEPTH)+1.
REQ-015 IDLE: start=1 SHALL clear the counter and move to LOAD next cycle; otherwise remain in IDLE.
REQ-016 LOAD: out_data SHALL register fifo_q, fifo_en SHALL be 1 for exactly this cycle, the counter SHALL increment, and the FSM SHALL move to SEND.
REQ-017 SEND: out_valid SHALL be 1; on out_valid&&out_ready the FSM SHALL move to DONE if counter==DEPTH, else to LOAD.
REQ-018 DONE: done SHALL be 1 for one cycle and the FSM SHALL return to IDLE.
REQ-019 out_data SHALL remain stable while out_valid=1 and out_ready=0; fifo_en SHALL stay 0 throughout SEND.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 fifo_en SHALL be decoded combinationally from state==LOAD; all other outputs are registered or decoded from state.
REQ-022 Peak throughput SHALL be one entry per two cycles; a DEPTH-entry drain with out_ready held at 1 SHALL take 2*DEPTH+1 cycles from the start cycle to the done pulse, inclusive.
REQ-023 Exactly DEPTH fifo_en pulses SHALL occur per completed transaction, so that all entries leave in order.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, counter 0, out_data 0, out_valid 0, done 0, busy 0 and fifo_en 0.
REQ-025 Reset mid-transaction SHALL abandon the drain without further fifo_en pulses; the next start SHALL begin a full DEPTH-entry drain.

Configuration
REQ-026 Macro FIFO_DRAIN_RESTORE_EN: when defined, fifo_d SHALL equal fifo_q, so each shift recirculates the entry and the FIFO contents are unchanged after a full drain (non-destructive read).
REQ-027 When FIFO_DRAIN_RESTORE_EN is undefined, fifo_d SHALL be constant 0, and the FIFO SHALL hold all zeros after a full drain.

Structure
REQ-028 Package fifo_pkg SHALL hold FIFO_DEPTH=8, FIFO_BITS=64 and the drain_state_t enum (IDLE, LOAD, SEND, DONE); the parameter defaults SHALL reference these constants.
REQ-029 The block SHALL be a single module with no sub-modules; the bench SHALL instantiate the existing delay FIFO as the attached FIFO.

Verification
REQ-030 Fill the FIFO with 1..8, pulse start, hold out_ready=1 -> out_data 1..8 in order, 8 fifo_en pulses, done 17 cycles after start, and FIFO contents all 0 (macro undefined).
REQ-031 Same stimulus with FIFO_DRAIN_RESTORE_EN defined -> out_data 1..8 and FIFO contents 1..8 after done.
REQ-032 Drop out_ready for 5 cycles when entry 3 becomes valid -> out_data stays 3, out_valid stays 1, no fifo_en pulse, and the remaining entries follow in order.
REQ-033 Pulse start again while busy -> no effect: exactly 8 entries and one done pulse.
REQ-034 Assert rst_n=0 after 3 entries are accepted -> out_valid, busy and fifo_en go to 0 immediately; after reset is released, a refill with 0xA0..0xA7 and a start yield 8 entries 0xA0..0xA7.
